// File: rtl/svo_tmds_dec.sv
// TMDS channel decoder: finds word alignment through bitslip requests, then
// decodes data, control and DE. Define SVO_TMDS_DEC_DISP_CHECK_EN to enable the disparity monitor.
module svo_tmds_dec #(
  parameter int LOCK_RUN         = 8,
  parameter int SEARCH_WORDS     = 1024,
  parameter int SLIP_WAIT_CYCLES = 4,
  parameter int LOSS_WORDS       = 4096,
  parameter int DISP_LIMIT       = 10
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [9:0]  din,
  input  logic        din_valid,
  output logic        bitslip,
  output logic        locked,
  output logic [7:0]  dout,
  output logic [1:0]  ctrl,
  output logic        de,
  output logic        dout_valid,
  output logic [15:0] err_cnt
);

  localparam int RUN_W  = $clog2(LOCK_RUN + 1);
  localparam int SRCH_W = $clog2(SEARCH_WORDS + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);
  localparam int LOSS_W = $clog2(LOSS_WORDS + 1);

  // rd must hold DISP_LIMIT+5 in 7 signed bits
  if (LOCK_RUN < 1 || SEARCH_WORDS < 1 || SLIP_WAIT_CYCLES < 1 || LOSS_WORDS < 1 ||
      DISP_LIMIT < 1 || DISP_LIMIT > 58) begin : g_bad_param
    $error("svo_tmds_dec: parameter out of range");
  end

  typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;

  state_t            state, state_nxt;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [SRCH_W-1:0] srch_q, srch_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              slip_d;

  logic              is_ctrl;
  logic [1:0]        tok;
  logic [7:0]        d, dec;

  always_comb begin
    is_ctrl = 1'b1;
    tok     = 2'b00;
    case (din)
      10'b1101010100: tok = 2'b00;
      10'b0010101011: tok = 2'b01;
      10'b0101010100: tok = 2'b10;
      10'b1010101011: tok = 2'b11;
      default:        is_ctrl = 1'b0;
    endcase
  end

  // undo the optional inversion, then the XOR/XNOR chain
  assign d      = din[9] ? ~din[7:0] : din[7:0];
  assign dec[0] = d[0];
  for (genvar i = 1; i < 8; i++) begin : g_dec
    assign dec[i] = din[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
  end

  always_comb begin
    state_nxt = state;
    run_d     = run_q;
    srch_d    = srch_q;
    wait_d    = wait_q;
    loss_d    = loss_q;
    slip_d    = 1'b0;
    case (state)
      SEARCH: begin
        if (din_valid) begin
          if (is_ctrl)
            run_d = (run_q == RUN_W'(LOCK_RUN)) ? run_q : run_q + RUN_W'(1);
          else
            run_d = '0;
          srch_d = (srch_q == SRCH_W'(SEARCH_WORDS)) ? srch_q : srch_q + SRCH_W'(1);
          // a lock on the same word as search expiry takes priority
          if (run_d == RUN_W'(LOCK_RUN)) begin
            state_nxt = LOCKED;
            run_d     = '0;
            srch_d    = '0;
          end else if (srch_d == SRCH_W'(SEARCH_WORDS)) begin
            state_nxt = SLIP_WAIT;
            slip_d    = 1'b1;
            run_d     = '0;
            srch_d    = '0;
            wait_d    = '0;
          end
        end
      end
      SLIP_WAIT: begin
        wait_d = (wait_q == WAIT_W'(SLIP_WAIT_CYCLES)) ? wait_q : wait_q + WAIT_W'(1);
        if (wait_d == WAIT_W'(SLIP_WAIT_CYCLES)) begin
          state_nxt = SEARCH;
          wait_d    = '0;
          run_d     = '0;
          srch_d    = '0;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (is_ctrl)
            loss_d = '0;
          else
            loss_d = (loss_q == LOSS_W'(LOSS_WORDS)) ? loss_q : loss_q + LOSS_W'(1);
          if (loss_d == LOSS_W'(LOSS_WORDS)) begin
            state_nxt = SEARCH;
            loss_d    = '0;
            run_d     = '0;
            srch_d    = '0;
          end
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= SEARCH;
      run_q      <= '0;
      srch_q     <= '0;
      wait_q     <= '0;
      loss_q     <= '0;
      bitslip    <= 1'b0;
      dout       <= '0;
      ctrl       <= '0;
      de         <= 1'b0;
      dout_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      run_q      <= run_d;
      srch_q     <= srch_d;
      wait_q     <= wait_d;
      loss_q     <= loss_d;
      bitslip    <= slip_d;
      dout_valid <= din_valid;
      // gating follows the state the word was sampled in
      if (din_valid) begin
        if (state != LOCKED) begin
          de   <= 1'b0;
          dout <= '0;
          ctrl <= 2'b00;
        end else if (is_ctrl) begin
          de   <= 1'b0;
          dout <= '0;
          ctrl <= tok;
        end else begin
          de   <= 1'b1;
          dout <= dec;
        end
      end
    end
  end

  assign locked = (state == LOCKED);

`ifdef SVO_TMDS_DEC_DISP_CHECK_EN
  localparam logic signed [7:0] LIM = 8'(DISP_LIMIT);

  logic signed [6:0] rd;
  logic signed [7:0] rd_sum;
  logic [3:0]        ones;
  logic              over;

  always_comb begin
    ones = '0;
    for (int k = 0; k < 10; k++) ones = ones + 4'(din[k]);
  end

  assign rd_sum = {rd[6], rd} + {4'b0, ones} - 8'sd5;
  assign over   = (rd_sum > LIM) || (rd_sum < -LIM);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd      <= '0;
      err_cnt <= '0;
    end else if (state == LOCKED) begin
      if (din_valid && !is_ctrl) begin
        if (over) begin
          rd <= '0;
          if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        end else begin
          rd <= rd_sum[6:0];
        end
      end
      if (state_nxt != LOCKED) rd <= '0;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule
